plic_gateway: RTL

Per-source interrupt gateway of the RISC-V PLIC. It converts one raw interrupt source, either level- or edge-triggered, into the pending bit that feeds the source's row of priority-arbitration cells. It also implements the claim/complete protocol, so at most one request from the source is outstanding at a time. Queued edge requests are held in a saturating counter. One instance sits per source, between the source pin and the pending input of the matrix.

---
 rtl/plic_gateway.sv | 95 +++++++++
 1 files changed

// File: rtl/plic_gateway.sv
// Per-source RISC-V PLIC interrupt gateway: level/edge request capture, claim/complete
// handshake and saturating edge queue. Define PLIC_GATEWAY_SYNC_EN for a 2-flop input synchronizer.
`timescale 1ns/1ps
module plic_gateway #(
  parameter int unsigned MAX_PENDING_COUNT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic edge_lvl_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o
);

  localparam int unsigned CNT_BITS = $clog2(MAX_PENDING_COUNT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_PENDING_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLAIMED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                src_q;
  logic                ip_q;
  logic                s;
  logic                rise;
  logic                req;
  logic                q_nz;
  logic                enq;
  logic                deq;

`ifdef PLIC_GATEWAY_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for asynchronous sources
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], src_i};
    end
  end

  assign s = sync_q[1];
`else
  assign s = src_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      ip_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= s;
      ip_q    <= (state_d == ST_PENDING);
    end
  end

  // Next state and edge queue; a rise seen outside an empty IDLE is queued
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = s & ~src_q;
    req     = edge_lvl_i ? rise : s;
    q_nz    = (cnt_q != '0);
    deq     = edge_lvl_i & (state_q == ST_IDLE) & q_nz;
    enq     = edge_lvl_i & rise & ((state_q != ST_IDLE) | q_nz);

    case (state_q)
      ST_IDLE:    if (req || (edge_lvl_i && q_nz)) state_d = ST_PENDING;
      ST_PENDING: if (claim_i) state_d = ST_CLAIMED;
      ST_CLAIMED: if (complete_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (!edge_lvl_i) begin
      cnt_d = '0;
    end else if (enq && !deq) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_BITS'(1);
    end else if (deq && !enq) begin
      cnt_d = cnt_q - CNT_BITS'(1);
    end
  end

  assign ip_o = ip_q;

endmodule
